// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1) feeding a small show-ahead byte FIFO.
// The optional macro UART_RX_PARITY_EN adds a parity bit: 8E1, or 8O1 when PARITY_ODD=1.
// Without the macro, parity_err is tied low and PARITY_ODD has no effect.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  input  logic                          clr_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic             rx_meta;
  logic             rxs;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             armed_q, armed_d;
  logic             push_c;
  logic             frame_set_c;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             par_set_c;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c, pop_c, wr_c, ovr_set_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM and bit-timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; armed blocks a held-low line (break) from restarting frames.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    par_set_c   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rxs) begin
            frame_set_c = 1'b1;
            armed_d     = 1'b0;
          end
`ifdef UART_RX_PARITY_EN
          par_set_c = (par_q != (^shreg_q ^ 1'(PARITY_ODD)));
          push_c    = rxs && !par_set_c;
`else
          push_c    = rxs;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign full_c    = (count_q == CNT_FULL);
  assign pop_c     = rd_en && rd_valid;
  assign wr_c      = push_c && (!full_c || pop_c);
  assign ovr_set_c = push_c && full_c && !pop_c;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    if (wr_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !wr_c) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q  <= count_d;
      rd_valid <= (count_d != '0);
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set_c   | (overrun   & ~clr_err);
      frame_err <= frame_set_c | (frame_err & ~clr_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_set_c | (parity_err & ~clr_err);
    end
  end
`else
  assign parity_err = 1'b0;

  // PARITY_ODD only matters for parity frames; this empty block keeps it referenced.
  if (PARITY_ODD > 1) begin : g_parity_odd_ignored
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic          frame_err;
  logic          parity_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .clr_err    (clr_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start, data and (optional) parity, then the stop bit up to the mid-stop sample cycle.
  task automatic frame_to_midstop(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      tick(CPB);
    end
    if (HAS_PAR) begin
      rxd = (^data) ^ par_flip;
      tick(CPB);
    end
    rxd = stop_bit;
    tick(11);
  endtask

  // Complete frame; a low stop bit is followed by one bit time of idle line.
  task automatic send(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    frame_to_midstop(data, stop_bit, par_flip);
    tick(5);
    rxd = 1'b1;
    if (!stop_bit) tick(CPB);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(3);
    tests_run++;
    if (rd_valid !== 1'b0 || fifo_count !== 3'd0 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_fifo: valid=%b count=%0d data=%h expected 0/0/00", rd_valid, fifo_count, rd_data);
    end
    tests_run++;
    if (overrun !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ovr=%b frm=%b par=%b expected 000", overrun, frame_err, parity_err);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    frame_to_midstop(8'hA5, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_latency: count=%0d at mid-stop expected 0", fifo_count);
    end
    tick(1);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL basic_rx: valid=%b data=%h count=%0d expected 1/a5/1", rd_valid, rd_data, fifo_count);
    end
    tick(4);
    pop();
    tests_run++;
    if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pop: count=%0d valid=%b expected 0/0", fifo_count, rd_valid);
    end
    pop();
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL pop_empty: count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd4 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill: count=%0d ovr=%b expected 4/0", fifo_count, overrun);
    end
    send(8'h05, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd4 || rd_data !== 8'h01 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun: count=%0d head=%h ovr=%b expected 4/01/1", fifo_count, rd_data, overrun);
    end
    clear_flags();
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clr: ovr=%b expected 0", overrun);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data !== exp_b[i] || rd_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL overrun_drain%0d: data=%h valid=%b expected %h/1", i, rd_data, rd_valid, exp_b[i]);
      end
      pop();
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL overrun_empty: count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_frame_error();
    send(8'h3C, 1'b0, 1'b0);
    tests_run++;
    if (frame_err !== 1'b1 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL frame_err: frm=%b count=%0d expected 1/0", frame_err, fifo_count);
    end
    send(8'h11, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h11 || frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_recover: count=%0d head=%h frm=%b expected 1/11/1", fifo_count, rd_data, frame_err);
    end
    clear_flags();
    pop();
    tests_run++;
    if (frame_err !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL frame_clr: frm=%b count=%0d expected 0/0", frame_err, fifo_count);
    end
  endtask

  task automatic test_break();
    rxd = 1'b0;
    tick(170 + (HAS_PAR ? CPB : 0));
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL break_err: frm=%b expected 1", frame_err);
    end
    clear_flags();
    tick(300);
    tests_run++;
    if (frame_err !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL break_rearm: frm=%b count=%0d expected 0/0", frame_err, fifo_count);
    end
    rxd = 1'b1;
    tick(4);
    send(8'h22, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h22) begin
      tests_failed++;
      $display("FAIL break_after: count=%0d head=%h expected 1/22", fifo_count, rd_data);
    end
    pop();
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    tests_run++;
    if (fifo_count !== 3'd0 || rd_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: count=%0d valid=%b frm=%b par=%b expected 0/0/0/0", fifo_count, rd_valid, frame_err, parity_err);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4] = '{8'h20, 8'h30, 8'h40, 8'h50};
    send(8'h10, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h30, 1'b1, 1'b0);
    send(8'h40, 1'b1, 1'b0);
    frame_to_midstop(8'h50, 1'b1, 1'b0);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tests_run++;
    if (fifo_count !== 3'd4 || overrun !== 1'b0 || rd_data !== 8'h20) begin
      tests_failed++;
      $display("FAIL full_pushpop: count=%0d ovr=%b head=%h expected 4/0/20", fifo_count, overrun, rd_data);
    end
    tick(4);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rd_data !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL full_drain%0d: data=%h expected %h", i, rd_data, exp_b[i]);
      end
      pop();
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send(8'h07, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h07 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_ok: count=%0d head=%h par=%b expected 1/07/0", fifo_count, rd_data, parity_err);
    end
    send(8'h07, 1'b1, 1'b1);
    tests_run++;
    if (fifo_count !== 3'd1 || parity_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_bad: count=%0d par=%b expected 1/1", fifo_count, parity_err);
    end
    clear_flags();
    pop();
  endtask
`endif

  task automatic test_reset_midframe();
    logic [7:0] partial = 8'h5A;
    send(8'h3C, 1'b0, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd1 || frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: count=%0d frm=%b expected 1/1", fifo_count, frame_err);
    end
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = partial[i];
      tick(CPB);
    end
    rxd = partial[4];
    tick(8);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fifo_count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: count=%0d valid=%b data=%h frm=%b ovr=%b expected 0/0/00/0/0", fifo_count, rd_valid, rd_data, frame_err, overrun);
    end
    rxd = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send(8'h5A, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== 3'd1 || rd_data !== 8'h5A || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset: count=%0d head=%h frm=%b expected 1/5a/0", fifo_count, rd_data, frame_err);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_error();
    test_break();
    test_glitch();
    test_full_push_pop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
